// File: rtl/conv_pkg.sv
// Shared constants, FSM encoding and pixel-index helper for the 3x3 convolution engine.
package conv_pkg;

  localparam int IMG_DIM  = 4;
  localparam int K_DIM    = 3;
  localparam int OUT_DIM  = 2;
  localparam int NUM_TAPS = K_DIM * K_DIM;
  localparam int NUM_OUT  = OUT_DIM * OUT_DIM;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Row-major image index of the pixel under tap (ky,kx) for output (r,c).
  function automatic logic [3:0] pix_idx(input logic [1:0] r, input logic [1:0] c,
                                         input logic [1:0] ky, input logic [1:0] kx);
    int idx;
    idx = (int'(r) + int'(ky)) * IMG_DIM + int'(c) + int'(kx);
    return idx[3:0];
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Unsigned DATA_W x DATA_W multiplier feeding an ACC_W accumulator with clear and enable.
module mac_unit #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc,
  output logic [ACC_W-1:0]  sum
);

  logic [2*DATA_W-1:0] prod;

  assign prod = a * b;
  assign sum  = acc + ACC_W'(prod);

  // Clear wins over enable so the final tap of a pixel can be written out and reset together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/conv_engine.sv
// Sequential 3x3 valid-mode convolution of a 4x4 image using one shared MAC, one tap per cycle.
module conv_engine
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] input_data0,
  input  logic [DATA_W-1:0] input_data1,
  input  logic [DATA_W-1:0] input_data2,
  input  logic [DATA_W-1:0] input_data3,
  input  logic [DATA_W-1:0] input_data4,
  input  logic [DATA_W-1:0] input_data5,
  input  logic [DATA_W-1:0] input_data6,
  input  logic [DATA_W-1:0] input_data7,
  input  logic [DATA_W-1:0] input_data8,
  input  logic [DATA_W-1:0] input_data9,
  input  logic [DATA_W-1:0] input_data10,
  input  logic [DATA_W-1:0] input_data11,
  input  logic [DATA_W-1:0] input_data12,
  input  logic [DATA_W-1:0] input_data13,
  input  logic [DATA_W-1:0] input_data14,
  input  logic [DATA_W-1:0] input_data15,
  input  logic [DATA_W-1:0] filter_data0,
  input  logic [DATA_W-1:0] filter_data1,
  input  logic [DATA_W-1:0] filter_data2,
  input  logic [DATA_W-1:0] filter_data3,
  input  logic [DATA_W-1:0] filter_data4,
  input  logic [DATA_W-1:0] filter_data5,
  input  logic [DATA_W-1:0] filter_data6,
  input  logic [DATA_W-1:0] filter_data7,
  input  logic [DATA_W-1:0] filter_data8,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  result0,
  output logic [ACC_W-1:0]  result1,
  output logic [ACC_W-1:0]  result2,
  output logic [ACC_W-1:0]  result3,
  output logic              result_valid
);

  state_t            state, nxt;
  logic [DATA_W-1:0] img_in [16];
  logic [DATA_W-1:0] flt_in [9];
  logic [DATA_W-1:0] img_q  [16];
  logic [DATA_W-1:0] flt_q  [9];
  logic [ACC_W-1:0]  res    [4];
  logic [1:0]        pos;
  logic [3:0]        tap;
  logic [3:0]        ky_full, kx_full;
  logic [3:0]        img_idx;
  logic [DATA_W-1:0] img_sel, flt_sel;
  logic              accept, last_tap, last_pos, mac_en, mac_clr;
  logic [ACC_W-1:0]  acc, sum;

  assign img_in = '{input_data0, input_data1, input_data2, input_data3,
                    input_data4, input_data5, input_data6, input_data7,
                    input_data8, input_data9, input_data10, input_data11,
                    input_data12, input_data13, input_data14, input_data15};
  assign flt_in = '{filter_data0, filter_data1, filter_data2, filter_data3, filter_data4,
                    filter_data5, filter_data6, filter_data7, filter_data8};

  assign last_tap = (tap == 4'(NUM_TAPS - 1));
  assign last_pos = (pos == 2'(NUM_OUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = MAC;
      MAC:     if (last_tap && last_pos) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    mac_en  = 1'b0;
    mac_clr = 1'b0;
    case (state)
      IDLE: begin
        accept  = start;
        mac_clr = start;
      end
      MAC: begin
        busy    = 1'b1;
        mac_en  = 1'b1;
        mac_clr = last_tap;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand selection: tap t walks the 3x3 window anchored at output position p.
  assign ky_full = tap / 4'd3;
  assign kx_full = tap % 4'd3;
  assign img_idx = pix_idx({1'b0, pos[1]}, {1'b0, pos[0]}, ky_full[1:0], kx_full[1:0]);
  assign img_sel = img_q[img_idx];
  assign flt_sel = flt_q[tap];

  mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (img_sel),
    .b   (flt_sel),
    .acc (acc),
    .sum (sum)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos          <= '0;
      tap          <= '0;
      result_valid <= 1'b0;
      for (int i = 0; i < 16; i++) img_q[i] <= '0;
      for (int i = 0; i < 9; i++)  flt_q[i] <= '0;
      for (int i = 0; i < 4; i++)  res[i]   <= '0;
    end else if (accept) begin
      img_q        <= img_in;
      flt_q        <= flt_in;
      pos          <= '0;
      tap          <= '0;
      result_valid <= 1'b0;
    end else if (mac_en) begin
      if (last_tap) begin
        res[pos] <= sum;
        tap      <= '0;
        pos      <= pos + 2'd1;
        if (last_pos) result_valid <= 1'b1;
      end else begin
        tap <= tap + 4'd1;
      end
    end
  end

  assign result0 = res[0];
  assign result1 = res[1];
  assign result2 = res[2];
  assign result3 = res[3];

endmodule

// File: tb/tb_conv_engine.sv
// Scoreboard bench for conv_engine: expected 2x2 outputs are queued at each start and checked at done.
module tb_conv_engine;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] img [16];
  logic [DATA_W-1:0] flt [9];
  logic              busy, done, result_valid;
  logic [ACC_W-1:0]  result0, result1, result2, result3;
  logic [ACC_W-1:0]  res [4];

  int checks = 0;
  int failures = 0;
  logic [4*ACC_W-1:0] sb [$];

  always #5 clk = ~clk;

  assign res[0] = result0;
  assign res[1] = result1;
  assign res[2] = result2;
  assign res[3] = result3;

  conv_engine #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .input_data0(img[0]), .input_data1(img[1]), .input_data2(img[2]), .input_data3(img[3]),
    .input_data4(img[4]), .input_data5(img[5]), .input_data6(img[6]), .input_data7(img[7]),
    .input_data8(img[8]), .input_data9(img[9]), .input_data10(img[10]), .input_data11(img[11]),
    .input_data12(img[12]), .input_data13(img[13]), .input_data14(img[14]), .input_data15(img[15]),
    .filter_data0(flt[0]), .filter_data1(flt[1]), .filter_data2(flt[2]), .filter_data3(flt[3]),
    .filter_data4(flt[4]), .filter_data5(flt[5]), .filter_data6(flt[6]), .filter_data7(flt[7]),
    .filter_data8(flt[8]),
    .busy(busy), .done(done),
    .result0(result0), .result1(result1), .result2(result2), .result3(result3),
    .result_valid(result_valid)
  );

  function automatic logic [ACC_W-1:0] model_pix(int r, int c);
    int s;
    s = 0;
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++)
        s += int'(img[(r + ky) * 4 + c + kx]) * int'(flt[ky * 3 + kx]);
    return ACC_W'(s);
  endfunction

  task automatic push_expected();
    logic [4*ACC_W-1:0] e;
    for (int p = 0; p < 4; p++) e[p*ACC_W +: ACC_W] = model_pix(p / 2, p % 2);
    sb.push_back(e);
  endtask

  function automatic logic [4*ACC_W-1:0] pop_expected();
    if (sb.size() == 0) return '0;
    return sb.pop_front();
  endfunction

  task automatic set_inputs(input int img_mode, input int flt_mode);
    for (int i = 0; i < 16; i++)
      case (img_mode)
        0: img[i] = 8'd1;
        1: img[i] = 8'(i);
        2: img[i] = 8'd255;
        default: img[i] = 8'($urandom_range(0, 255));
      endcase
    for (int i = 0; i < 9; i++)
      case (flt_mode)
        0: flt[i] = 8'd1;
        1: flt[i] = (i == 4) ? 8'd1 : 8'd0;
        2: flt[i] = (i == 0) ? 8'd1 : 8'd0;
        3: flt[i] = 8'd255;
        default: flt[i] = 8'($urandom_range(0, 255));
      endcase
  endtask

  task automatic start_run();
    @(posedge clk); #1 start = 1'b1;
    push_expected();
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Waits for done; cycle n is the n-th cycle after the start edge. inject_at>0 pulses start mid-run.
  task automatic wait_done(input int inject_at, output int cyc, output int busy_cnt);
    cyc = -1;
    busy_cnt = 0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (inject_at > 0 && n == inject_at) begin
        start = 1'b1;
        set_inputs(9, 9);
      end
      if (inject_at > 0 && n == inject_at + 1) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    set_inputs(0, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl busy=%b done=%b rv=%b required 0 0 0", busy, done, result_valid);
    end
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (res[p] !== '0) begin
        failures++;
        $display("FAIL reset_result%0d got %0d required 0", p, res[p]);
      end
    end
    rst = 1'b1;
  endtask

  task automatic run_and_check(input string name, input int inject_at);
    int cyc, bc;
    logic [4*ACC_W-1:0] e;
    start_run();
    wait_done(inject_at, cyc, bc);
    e = pop_expected();
    checks++;
    if (cyc != 37) begin
      failures++;
      $display("FAIL %s_done_latency got %0d required 37", name, cyc);
    end
    checks++;
    if (bc != 37) begin
      failures++;
      $display("FAIL %s_busy_cycles got %0d required 37", name, bc);
    end
    checks++;
    if (result_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_result_valid got %b required 1", name, result_valid);
    end
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (res[p] !== e[p*ACC_W +: ACC_W]) begin
        failures++;
        $display("FAIL %s_result%0d got %0d required %0d", name, p, res[p], e[p*ACC_W +: ACC_W]);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_after_done done=%b busy=%b required 0 0", name, done, busy);
    end
  endtask

  task automatic test_ones();
    set_inputs(0, 0);
    run_and_check("ones", 0);
    checks++;
    if (result0 !== 20'd9) begin
      failures++;
      $display("FAIL ones_const got %0d required 9", result0);
    end
  endtask

  task automatic test_center();
    set_inputs(1, 1);
    run_and_check("center", 0);
    checks++;
    if (result0 !== 20'd5 || result1 !== 20'd6 || result2 !== 20'd9 || result3 !== 20'd10) begin
      failures++;
      $display("FAIL center_const got %0d %0d %0d %0d required 5 6 9 10", result0, result1, result2, result3);
    end
  endtask

  task automatic test_corner();
    set_inputs(1, 2);
    run_and_check("corner", 0);
    checks++;
    if (result0 !== 20'd0 || result1 !== 20'd1 || result2 !== 20'd4 || result3 !== 20'd5) begin
      failures++;
      $display("FAIL corner_const got %0d %0d %0d %0d required 0 1 4 5", result0, result1, result2, result3);
    end
  endtask

  task automatic test_max();
    set_inputs(2, 3);
    run_and_check("max", 0);
    checks++;
    if (result3 !== 20'd585225) begin
      failures++;
      $display("FAIL max_const got %0d required 585225", result3);
    end
  endtask

  task automatic test_start_ignored();
    int dc;
    set_inputs(9, 9);
    run_and_check("ignored", 10);
    dc = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dc++;
    end
    checks++;
    if (dc != 0) begin
      failures++;
      $display("FAIL ignored_extra_done got %0d required 0", dc);
    end
  endtask

  task automatic test_reset_mid();
    logic [4*ACC_W-1:0] e;
    set_inputs(9, 9);
    start_run();
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    e = pop_expected();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_ctrl busy=%b done=%b rv=%b required 0 0 0", busy, done, result_valid);
    end
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (res[p] !== '0) begin
        failures++;
        $display("FAIL midreset_result%0d got %0d required 0", p, res[p]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    set_inputs(1, 9);
    run_and_check("after_reset", 0);
  endtask

  task automatic test_back_to_back();
    int cyc, bc;
    logic [4*ACC_W-1:0] e;
    set_inputs(9, 9);
    start_run();
    wait_done(0, cyc, bc);
    e = pop_expected();
    checks++;
    if (cyc != 37 || result0 !== e[0 +: ACC_W]) begin
      failures++;
      $display("FAIL b2b_first latency=%0d r0=%0d required 37 %0d", cyc, result0, e[0 +: ACC_W]);
    end
    set_inputs(1, 0);
    start_run();
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept rv=%b busy=%b required 0 1", result_valid, busy);
    end
    wait_done(0, cyc, bc);
    e = pop_expected();
    checks++;
    if (cyc != 37) begin
      failures++;
      $display("FAIL b2b_second_latency got %0d required 37", cyc);
    end
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (res[p] !== e[p*ACC_W +: ACC_W]) begin
        failures++;
        $display("FAIL b2b_result%0d got %0d required %0d", p, res[p], e[p*ACC_W +: ACC_W]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_center();
    test_corner();
    test_max();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_engine.md
Name: conv_engine

Overview:
Sequential 3x3 convolution engine directly downstream of the memory block. It consumes the 16-byte 4x4 input image (input_data0..15, row-major) and the 9-byte 3x3 filter (filter_data0..8, row-major). On a start pulse it snapshots all operands and computes the four valid-mode output pixels (2x2) with a single multiply-accumulate unit. It then presents the results with a done pulse.

Parameters:
DATA_W, 8, width of each image/filter byte (unsigned)
ACC_W, 20, accumulator/result width; must be >= 2*DATA_W+4 (9 products)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
start  in  1  single-cycle request; sampled only in IDLE
input_data0..input_data15  in  DATA_W each  image pixel [row*4+col]
filter_data0..filter_data8  in  DATA_W each  filter tap [ky*3+kx]
busy  out  1  high while a computation is in progress (MAC or DONE)
done  out  1  one-cycle pulse when all four results are final
result0..result3  out  ACC_W each  output pixel [r*2+c]
result_valid  out  1  high from done until next accepted start

Behaviour:
- Reset (rst=0, async): state=IDLE; busy=0, done=0, result_valid=0, result0..3=0. Accumulator, tap index and position index are all 0. Operand snapshot is cleared.
- FSM states: IDLE, MAC, DONE.
- IDLE: start=1 at edge E0 captures all 25 operands into internal registers. The same edge clears acc, sets pos=0 and tap=0, clears result_valid, and moves to MAC. The inputs are don't-care after E0.
- MAC: one tap per cycle.
  - Position p gives r=p/2, c=p%2. Tap t gives ky=t/3, kx=t%3.
  - Each cycle computes product = img[(r+ky)*4+(c+kx)] * flt[t], unsigned, 2*DATA_W bits, zero-extended to ACC_W.
  - At t<8: acc <= acc+product, t <= t+1.
  - At t=8: result[p] <= acc+product, acc <= 0, t <= 0.
    - If p<3, p <= p+1 and stay in MAC.
    - If p=3, go to DONE.
- MAC occupies exactly 36 cycles (E0+1 .. E0+36).
- DONE: lasts one cycle, the 37th after E0. done=1 and result_valid is set at entry. Next edge returns to IDLE.
- busy=1 in MAC and DONE, 0 in IDLE.
- result0..3 update only at their own t=8 edge. Each holds its value until overwritten by a later run or cleared by reset.
- No overflow is possible with the defaults (max 9*255*255 = 585225 < 2^20). No saturation logic.
- start while busy is ignored and not queued.
- start high in the IDLE cycle immediately after DONE is accepted (back-to-back runs are allowed).
- Reset asserted mid-run aborts immediately to reset values. No partial results are retained.

Decomposition:
- conv_pkg holds:
  - constants IMG_DIM=4, K_DIM=3, OUT_DIM=2, NUM_TAPS=9, NUM_OUT=4
  - state encoding typedef (IDLE/MAC/DONE)
  - pixel-index helper function (r, c, ky, kx -> 0..15)
- Sub-module mac_unit: DATA_W x DATA_W unsigned multiply plus ACC_W accumulate register, with clear and enable inputs. conv_engine instantiates it once. Operand selection muxes and the FSM remain in conv_engine.

Test Plan:
- All pixels=1, all taps=1, start pulse -> done exactly 37 cycles after start edge; result0..3 = 9; busy high 37 cycles.
- Pixels = index 0..15, filter_data4=1, others 0 -> result0..3 = 5, 6, 9, 10; result_valid=1 after done.
- Pixels = index 0..15, filter_data0=1, others 0 -> result0..3 = 0, 1, 4, 5.
- All pixels and taps = 255 -> each result = 585225, no wrap.
- Start pulse again at cycle 10 of a run; also change inputs after E0 -> ignored; results match the original snapshot; only one done pulse.
- Assert rst at MAC cycle 20 -> all outputs 0 immediately, FSM IDLE. A new start afterwards gives correct results.
- Start re-asserted in the cycle right after done -> second run accepted; result_valid drops at its start; second done 37 cycles later.
